// File: rtl/fp_addsub_mc.sv
`default_nettype none
// ============================================================================
//  Module   : fp_addsub_mc
//  Purpose  : Multicycle IEEE-754-style floating-point adder/subtractor,
//             generic in exponent/fraction width, round-to-nearest-even,
//             denormals flushed to zero, start/done handshake, fixed latency.
//  Revision : 1.0  initial release
// ============================================================================
module fp_addsub_mc #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 2**(EXP_W-1)-1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   op,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   done,
    output logic                   busy,
    output logic                   flag_invalid,
    output logic                   flag_overflow,
    output logic                   flag_underflow,
    output logic                   flag_inexact
);

    localparam int c_W    = 1 + EXP_W + MAN_W;
    localparam int c_F    = MAN_W + 4;          // hidden, fraction, guard, round, sticky
    localparam int c_LZW  = $clog2(c_F);
    localparam int c_XW   = EXP_W + 2;          // exponent with headroom for carry / compares
    localparam int c_EMAX = 2**EXP_W - 1;
    localparam logic [EXP_W-1:0] c_EONES = {EXP_W{1'b1}};
    localparam logic [c_W-1:0]   c_QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // The bias never enters the arithmetic (only exponent differences do),
    // but a nonsensical value is still rejected at elaboration.
    generate
        if (BIAS < 1 || BIAS >= 2**EXP_W - 1) begin : g_bias_check
            $error("fp_addsub_mc: BIAS out of range for EXP_W");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4
    } state_t;

    state_t            r_state;
    logic [c_W-1:0]    r_a;
    logic [c_W-1:0]    r_b;
    logic              r_force;     // result already decided (special, exact zero, underflow)
    logic [c_W-1:0]    r_fres;
    logic [3:0]        r_fflags;    // {invalid, overflow, underflow, inexact}
    logic              r_sx;
    logic              r_sub;
    logic [c_XW-1:0]   r_ex;
    logic [c_F-1:0]    r_mx;
    logic [c_F-1:0]    r_my;
    logic [c_F:0]      r_sum;
    logic [c_F-1:0]    r_m;
    logic [c_XW-1:0]   r_e;

    // ALIGN stage signals
    logic              w_sa, w_sb, w_sx;
    logic [EXP_W-1:0]  w_ea, w_eb, w_ex, w_ey, w_d;
    logic [MAN_W-1:0]  w_fa, w_fb, w_fam, w_fbm, w_fx, w_fy;
    logic              w_za, w_zb, w_zy, w_ia, w_ib, w_na, w_nb, w_swap;
    logic [c_F-1:0]    w_sigx, w_sigy, w_ysh, w_my;
    logic              w_lost;
    logic              w_spec;
    logic [c_W-1:0]    w_sres;
    logic [3:0]        w_sflags;

    // Unpack, resolve specials, order by magnitude and align the smaller operand
    always_comb begin
        w_sa   = r_a[c_W-1];
        w_sb   = r_b[c_W-1];
        w_ea   = r_a[c_W-2:MAN_W];
        w_eb   = r_b[c_W-2:MAN_W];
        w_fa   = r_a[MAN_W-1:0];
        w_fb   = r_b[MAN_W-1:0];
        w_za   = (w_ea == '0);
        w_zb   = (w_eb == '0);
        w_ia   = (w_ea == c_EONES) && (w_fa == '0);
        w_ib   = (w_eb == c_EONES) && (w_fb == '0);
        w_na   = (w_ea == c_EONES) && (w_fa != '0);
        w_nb   = (w_eb == c_EONES) && (w_fb != '0);
        // Denormal fractions are discarded so they compare and add as zero
        w_fam  = w_za ? '0 : w_fa;
        w_fbm  = w_zb ? '0 : w_fb;
        w_swap = {w_eb, w_fbm} > {w_ea, w_fam};
        w_sx   = w_swap ? w_sb  : w_sa;
        w_ex   = w_swap ? w_eb  : w_ea;
        w_ey   = w_swap ? w_ea  : w_eb;
        w_fx   = w_swap ? w_fbm : w_fam;
        w_fy   = w_swap ? w_fam : w_fbm;
        w_zy   = w_swap ? w_za  : w_zb;
        w_d    = w_ex - w_ey;
        w_sigx = {1'b1, w_fx, 3'b000};
        w_sigy = {~w_zy, w_fy, 3'b000};
        w_ysh  = w_sigy >> w_d;
        w_lost = |(w_sigy & ~({c_F{1'b1}} << w_d));
        if (32'(w_d) >= c_F - 1) begin
            w_my = {{(c_F-1){1'b0}}, |w_sigy};
        end else begin
            w_my = {w_ysh[c_F-1:1], w_ysh[0] | w_lost};
        end

        w_spec   = 1'b1;
        w_sres   = '0;
        w_sflags = 4'b0000;
        if (w_na || w_nb || (w_ia && w_ib && (w_sa != w_sb))) begin
            w_sres   = c_QNAN;
            w_sflags = 4'b1000;
        end else if (w_ia) begin
            w_sres = r_a;
        end else if (w_ib) begin
            w_sres = r_b;
        end else if (w_za && w_zb) begin
            w_sres = {w_sa & w_sb, {(c_W-1){1'b0}}};
        end else begin
            w_spec = 1'b0;
        end
    end

    // NORM stage signals
    logic [c_LZW-1:0]  w_lzc;
    logic [c_F-1:0]    w_nm;
    logic [c_XW-1:0]   w_ne;
    logic              w_uflow;

    // Leading-zero priority encoder and normalisation shift
    always_comb begin
        w_lzc = '0;
        for (int i = 0; i < c_F; i++) begin
            if (r_sum[i]) begin
                w_lzc = c_LZW'(c_F - 1 - i);
            end
        end
        w_uflow = 1'b0;
        if (r_sum[c_F]) begin
            w_nm = {r_sum[c_F:2], r_sum[1] | r_sum[0]};
            w_ne = r_ex + c_XW'(1);
        end else begin
            w_nm    = r_sum[c_F-1:0] << w_lzc;
            w_ne    = r_ex - c_XW'(w_lzc);
            w_uflow = (r_ex <= c_XW'(w_lzc));
        end
    end

    // ROUND stage signals
    logic              w_up;
    logic [MAN_W+1:0]  w_mant;
    logic [c_XW-1:0]   w_re;
    logic [MAN_W-1:0]  w_rfrac;
    logic              w_ovf;
    logic              w_inex;

    // Round-to-nearest-even on guard/round/sticky, then overflow detection
    always_comb begin
        w_inex  = r_m[2] | r_m[1] | r_m[0];
        w_up    = r_m[2] & (r_m[1] | r_m[0] | r_m[3]);
        w_mant  = {1'b0, r_m[c_F-1:3]} + (MAN_W+2)'(w_up);
        w_re    = r_e + c_XW'(w_mant[MAN_W+1]);
        w_rfrac = w_mant[MAN_W+1] ? w_mant[MAN_W:1] : w_mant[MAN_W-1:0];
        w_ovf   = (w_re >= c_XW'(c_EMAX));
    end

    // Control FSM with datapath registers; result and flags change only on done
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            result         <= '0;
            done           <= 1'b0;
            busy           <= 1'b0;
            flag_invalid   <= 1'b0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= {b[c_W-1] ^ op, b[c_W-2:0]};
                        busy    <= 1'b1;
                        r_state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    r_force  <= w_spec;
                    r_fres   <= w_sres;
                    r_fflags <= w_sflags;
                    r_sx     <= w_sx;
                    r_sub    <= w_sa ^ w_sb;
                    r_ex     <= c_XW'(w_ex);
                    r_mx     <= w_sigx;
                    r_my     <= w_my;
                    r_state  <= S_ADD;
                end
                S_ADD: begin
                    // X is the larger magnitude, so the difference never goes negative
                    if (r_sub) begin
                        r_sum <= {1'b0, r_mx} - {1'b0, r_my};
                    end else begin
                        r_sum <= {1'b0, r_mx} + {1'b0, r_my};
                    end
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    if (!r_force) begin
                        if (r_sum == '0) begin
                            r_force  <= 1'b1;
                            r_fres   <= '0;
                            r_fflags <= 4'b0000;
                        end else if (w_uflow) begin
                            r_force  <= 1'b1;
                            r_fres   <= {r_sx, {(c_W-1){1'b0}}};
                            r_fflags <= 4'b0011;
                        end
                    end
                    r_m     <= w_nm;
                    r_e     <= w_ne;
                    r_state <= S_ROUND;
                end
                S_ROUND: begin
                    if (r_force) begin
                        result <= r_fres;
                        {flag_invalid, flag_overflow, flag_underflow, flag_inexact} <= r_fflags;
                    end else if (w_ovf) begin
                        result <= {r_sx, c_EONES, {MAN_W{1'b0}}};
                        {flag_invalid, flag_overflow, flag_underflow, flag_inexact} <= 4'b0101;
                    end else begin
                        result <= {r_sx, w_re[EXP_W-1:0], w_rfrac};
                        {flag_invalid, flag_overflow, flag_underflow, flag_inexact} <= {3'b000, w_inex};
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_addsub_mc
//  Purpose  : Self-checking bench for fp_addsub_mc (single and half precision)
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_addsub_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        s_start = 1'b0, s_op = 1'b0;
    logic [31:0] s_a = '0, s_b = '0, s_result;
    logic        s_done, s_busy, s_inv, s_ovf, s_unf, s_inx;
    logic        h_start = 1'b0, h_op = 1'b0;
    logic [15:0] h_a = '0, h_b = '0, h_result;
    logic        h_done, h_busy, h_inv, h_ovf, h_unf, h_inx;

    fp_addsub_mc dut (
        .clk(clk), .reset(reset), .start(s_start), .op(s_op), .a(s_a), .b(s_b),
        .result(s_result), .done(s_done), .busy(s_busy),
        .flag_invalid(s_inv), .flag_overflow(s_ovf),
        .flag_underflow(s_unf), .flag_inexact(s_inx)
    );

    fp_addsub_mc #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .reset(reset), .start(h_start), .op(h_op), .a(h_a), .b(h_b),
        .result(h_result), .done(h_done), .busy(h_busy),
        .flag_invalid(h_inv), .flag_overflow(h_ovf),
        .flag_underflow(h_unf), .flag_inexact(h_inx)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] pk(input int ew, input int mw, input logic s,
                                       input int e, input logic [31:0] f);
        logic [31:0] fm;
        fm = (32'd1 << mw) - 32'd1;
        return (32'(s) << (ew + mw)) | (32'(e) << mw) | (f & fm);
    endfunction

    // Reference: exact integer sum of the two values, then IEEE rounding.
    // Returns {invalid, overflow, underflow, inexact, result[31:0]}.
    function automatic logic [35:0] ref_model(input int ew, input int mw,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic op);
        int          emx, ea, eb, e, p, sh;
        logic        sa, sb, sr;
        logic [31:0] fa, fb, fm, qnan;
        logic [319:0] na, nb, mag, kept, rem, half;
        bit          za, zb, ia, ib, xa, xb, inex;
        emx  = (1 << ew) - 1;
        fm   = (32'd1 << mw) - 32'd1;
        qnan = pk(ew, mw, 1'b0, emx, 32'd1 << (mw - 1));
        sa   = a[ew+mw];
        sb   = b[ew+mw] ^ op;
        ea   = int'((a >> mw) & 32'(emx));
        eb   = int'((b >> mw) & 32'(emx));
        fa   = a & fm;
        fb   = b & fm;
        za   = (ea == 0);
        zb   = (eb == 0);
        ia   = (ea == emx) && (fa == 0);
        ib   = (eb == emx) && (fb == 0);
        xa   = (ea == emx) && (fa != 0);
        xb   = (eb == emx) && (fb != 0);
        if (xa || xb || (ia && ib && sa != sb)) return {4'b1000, qnan};
        if (ia) return {4'b0000, pk(ew, mw, sa, emx, 0)};
        if (ib) return {4'b0000, pk(ew, mw, sb, emx, 0)};
        if (za && zb) return {4'b0000, pk(ew, mw, sa & sb, 0, 0)};
        na = za ? '0 : (320'((32'd1 << mw) | fa) << (ea - 1));
        nb = zb ? '0 : (320'((32'd1 << mw) | fb) << (eb - 1));
        if (sa == sb) begin
            mag = na + nb; sr = sa;
        end else if (na >= nb) begin
            mag = na - nb; sr = sa;
        end else begin
            mag = nb - na; sr = sb;
        end
        if (mag == '0) return {4'b0000, 32'd0};
        p = 0;
        for (int i = 319; i >= 0; i--) begin
            if (mag[i]) begin p = i; break; end
        end
        e = p - mw + 1;
        if (e <= 0) return {4'b0011, pk(ew, mw, sr, 0, 0)};
        sh   = p - mw;
        kept = mag >> sh;
        rem  = mag & ((320'd1 << sh) - 320'd1);
        half = (sh > 0) ? (320'd1 << (sh - 1)) : '0;
        inex = (rem != '0);
        if (sh > 0 && (rem > half || (rem == half && kept[0]))) kept = kept + 320'd1;
        if (kept[mw+1]) begin
            kept = kept >> 1;
            e++;
        end
        if (e >= emx) return {4'b0101, pk(ew, mw, sr, emx, 0)};
        return {3'b000, inex, pk(ew, mw, sr, e, kept[31:0])};
    endfunction

    function automatic bit get_done(input bit hp);
        return hp ? h_done : s_done;
    endfunction

    function automatic bit get_busy(input bit hp);
        return hp ? h_busy : s_busy;
    endfunction

    // One operation: start for one edge, then count cycles until done.
    task automatic run_op(input bit hp, input logic op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [3:0] fl,
                          output int lat, output int nbusy, output bit busy_at_done);
        @(negedge clk);
        if (hp) begin
            h_start = 1'b1; h_op = op; h_a = a[15:0]; h_b = b[15:0];
        end else begin
            s_start = 1'b1; s_op = op; s_a = a; s_b = b;
        end
        @(posedge clk);
        #1;
        s_start = 1'b0;
        h_start = 1'b0;
        lat = 0;
        nbusy = 0;
        while (!get_done(hp) && lat < 12) begin
            if (get_busy(hp)) nbusy++;
            @(posedge clk);
            #1;
            lat++;
        end
        busy_at_done = get_busy(hp);
        if (hp) begin
            res = {16'h0000, h_result}; fl = {h_inv, h_ovf, h_unf, h_inx};
        end else begin
            res = s_result; fl = {s_inv, s_ovf, s_unf, s_inx};
        end
    endtask

    typedef struct {
        bit          hp;
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;    // {invalid, overflow, underflow, inexact}
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [31:0] res, r1;
        logic [3:0]  fl;
        int          lat, nbusy, ndone, firstk;
        bit          bad;

        tbl.push_back('{0, 1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'b0000});
        tbl.push_back('{0, 1'b0, 32'h3FC00000, 32'h40100000, 32'h40700000, 4'b0000});
        tbl.push_back('{0, 1'b1, 32'h3F800000, 32'h3F000000, 32'h3F000000, 4'b0000});
        tbl.push_back('{0, 1'b0, 32'hBF800000, 32'h3F800000, 32'h00000000, 4'b0000});
        tbl.push_back('{0, 1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0001});
        tbl.push_back('{0, 1'b0, 32'h3F800000, 32'h33800001, 32'h3F800001, 4'b0001});
        tbl.push_back('{0, 1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0101});
        tbl.push_back('{0, 1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000});
        tbl.push_back('{0, 1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000});
        tbl.push_back('{0, 1'b0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b1000});
        tbl.push_back('{0, 1'b0, 32'h3F800000, 32'hFF800000, 32'hFF800000, 4'b0000});
        tbl.push_back('{0, 1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 4'b0000});
        tbl.push_back('{0, 1'b1, 32'h80000000, 32'h00000000, 32'h80000000, 4'b0000});
        tbl.push_back('{0, 1'b0, 32'h00000001, 32'h00000000, 32'h00000000, 4'b0000});
        tbl.push_back('{0, 1'b1, 32'h00800000, 32'h00800001, 32'h80000000, 4'b0011});
        tbl.push_back('{0, 1'b0, 32'h00800000, 32'h00800000, 32'h01000000, 4'b0000});
        tbl.push_back('{0, 1'b1, 32'h3F800001, 32'h3F800000, 32'h34000000, 4'b0000});
        tbl.push_back('{1, 1'b0, 32'h00003C00, 32'h00003C00, 32'h00004000, 4'b0000});
        tbl.push_back('{1, 1'b0, 32'h00007BFF, 32'h00007BFF, 32'h00007C00, 4'b0101});
        tbl.push_back('{1, 1'b1, 32'h00003C00, 32'h00003800, 32'h00003800, 4'b0000});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_sp", {s_result, s_done, s_busy, s_inv, s_ovf, s_unf, s_inx}, '0);
        check("reset_hp", {h_result, h_done, h_busy, h_inv, h_ovf, h_unf, h_inx}, '0);

        // Directed table
        foreach (tbl[i]) begin
            run_op(tbl[i].hp, tbl[i].op, tbl[i].a, tbl[i].b, res, fl, lat, nbusy, bad);
            check($sformatf("vec%0d", i), {fl, res}, {tbl[i].fl, tbl[i].res});
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
            if (i == 0) begin
                check("busy_cycles", 64'(nbusy), 64'd4);
                check("busy_at_done", 64'(bad), 64'd0);
            end
        end

        // Result and flags hold after done until the next operation
        run_op(0, 1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, res, fl, lat, nbusy, bad);
        repeat (3) @(posedge clk);
        #1;
        check("hold", {s_done, s_inv, s_ovf, s_unf, s_inx, s_result}, {1'b0, 4'b0101, 32'h7F800000});

        // start held high during cycles 1-3 is ignored
        @(negedge clk);
        s_start = 1'b1; s_op = 1'b0; s_a = 32'h3F800000; s_b = 32'h3F800000;
        @(posedge clk);
        #1;
        s_a = 32'h40400000; s_b = 32'h40400000;
        ndone = 0; firstk = 0; r1 = '0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) s_start = 1'b0;
            if (s_done) begin
                ndone++;
                if (firstk == 0) begin firstk = k; r1 = s_result; end
            end
        end
        check("ignore_start_dones", 64'(ndone), 64'd1);
        check("ignore_start_latency", 64'(firstk), 64'd4);
        check("ignore_start_result", 64'(r1), 64'h40000000);

        // Back-to-back: the next start lands on the done cycle
        run_op(0, 1'b0, 32'h3F800000, 32'h3F800000, res, fl, lat, nbusy, bad);
        run_op(0, 1'b0, 32'h3FC00000, 32'h40100000, res, fl, lat, nbusy, bad);
        check("b2b_latency", 64'(lat), 64'd4);
        check("b2b_result", {fl, res}, {4'b0000, 32'h40700000});

        // Reset at cycle 2 aborts the operation
        run_op(0, 1'b0, 32'h7F800000, 32'hFF800000, res, fl, lat, nbusy, bad);
        @(negedge clk);
        s_start = 1'b1; s_op = 1'b0; s_a = 32'h3F800000; s_b = 32'h3F800000;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            if (s_done) ndone++;
            @(posedge clk);
            #1;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        check("abort_state", {s_result, s_busy, s_inv, s_ovf, s_unf, s_inx}, '0);

        // Randomised operands against the reference model
        for (int i = 0; i < 360; i++) begin
            bit          hp;
            int          ew, mw, emx, ea, eb, mode, t;
            logic [31:0] ra, rb;
            logic        rop;
            logic [35:0] expv;
            hp   = (i % 3 == 2);
            ew   = hp ? 5 : 8;
            mw   = hp ? 10 : 23;
            emx  = (1 << ew) - 1;
            mode = int'($urandom_range(0, 5));
            ea   = int'($urandom_range(1, 32'(emx - 1)));
            case (mode)
                0: eb = int'($urandom_range(1, 32'(emx - 1)));
                1: begin
                    t = ea + int'($urandom_range(0, 6)) - 3;
                    if (t < 0) t = 0;
                    if (t > emx - 1) t = emx - 1;
                    eb = t;
                end
                2: eb = ea;
                3: begin
                    ea = int'($urandom_range(1, 3));
                    eb = int'($urandom_range(0, 3));
                end
                4: begin
                    ea = emx - 1;
                    eb = emx - int'($urandom_range(1, 3));
                end
                default: eb = ($urandom_range(0, 1) != 0) ? 0 : emx;
            endcase
            ra  = pk(ew, mw, 1'($urandom_range(0, 1)), ea, $urandom);
            rb  = pk(ew, mw, 1'($urandom_range(0, 1)), eb, $urandom);
            if (mode == 2 && $urandom_range(0, 1) != 0)
                rb = pk(ew, mw, 1'($urandom_range(0, 1)), eb, ra ^ 32'($urandom_range(0, 7)));
            if (mode == 5 && $urandom_range(0, 1) != 0)
                rb = pk(ew, mw, 1'($urandom_range(0, 1)), eb, 32'd0);
            rop  = 1'($urandom_range(0, 1));
            expv = ref_model(ew, mw, ra, rb, rop);
            run_op(hp, rop, ra, rb, res, fl, lat, nbusy, bad);
            check($sformatf("rand%0d %h %s %h", i, ra, rop ? "-" : "+", rb), {fl, res}, expv);
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'd4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
